// File: rtl/gf180mcu_fd_sc_mcu7t5v0__aoi_pipe_pkg.sv
// Shared helpers for the pipelined AOI block: width math, parameter range
// checking and the {ZN, MULTI, GRP_IDX} result triple layout.
`ifndef GF180MCU_AOI_PIPE_PKG_SV
`define GF180MCU_AOI_PIPE_PKG_SV

// Result triple; the index field width follows the owning instance's GW.
`define AOI_PIPE_TRIPLE_T(gw) struct packed { \
  logic zn; \
  logic multi; \
  logic [(gw)-1:0] grp_idx; \
}

// Elaboration-time guard that stops a build with an out-of-range parameter.
`define AOI_PIPE_CHECK_RANGE(label, name, value, lo, hi) \
  if ((value) < (lo) || (value) > (hi)) begin : label \
    $error("%s=%0d is outside %0d..%0d", name, value, lo, hi); \
  end

`endif

package gf180mcu_fd_sc_mcu7t5v0__aoi_pipe_pkg;

  localparam int GROUPS_MIN = 2;
  localparam int GROUPS_MAX = 16;
  localparam int TERMS_MIN  = 1;
  localparam int TERMS_MAX  = 8;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // GRP_IDX must also encode the "no group true" value GROUPS.
  function automatic int aoi_gw(input int groups);
    return clog2(groups + 1);
  endfunction

  typedef `AOI_PIPE_TRIPLE_T(aoi_gw(3)) triple_default_t;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__aoi_pipe_stage.sv
// One valid/ready register slice; the payload type is supplied by the parent
// so the same slice carries any triple width.
module gf180mcu_fd_sc_mcu7t5v0__aoi_pipe_stage #(
  parameter type T          = logic,
  parameter T    RESET_DATA = T'(0)
) (
  input  logic clk,
  input  logic rst,
  input  logic up_valid,
  input  T     up_data,
  input  logic dn_ready,
  output logic dn_valid,
  output T     dn_data
);

  logic load;

  assign load = ~dn_valid | dn_ready;

  // An empty upstream slot only clears valid; the payload keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      dn_valid <= 1'b0;
      dn_data  <= RESET_DATA;
    end else if (load) begin
      dn_valid <= up_valid;
      if (up_valid) dn_data <= up_data;
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__aoi_pipe.sv
// Parametrised AND-OR-INVERT evaluation with group-hit flags, followed by a
// chain of valid/ready register slices.
module gf180mcu_fd_sc_mcu7t5v0__aoi_pipe
  import gf180mcu_fd_sc_mcu7t5v0__aoi_pipe_pkg::*;
#(
  parameter  int GROUPS = 3,
  parameter  int TERMS  = 2,
  parameter  int INVERT = 1,
  parameter  int STAGES = 1,
  localparam int GW     = aoi_gw(GROUPS)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [GROUPS*TERMS-1:0] A,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  output logic                    ZN,
  output logic                    MULTI,
  output logic [GW-1:0]           GRP_IDX,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY
);

  `AOI_PIPE_CHECK_RANGE(g_chk_groups, "GROUPS", GROUPS, GROUPS_MIN, GROUPS_MAX)
  `AOI_PIPE_CHECK_RANGE(g_chk_terms, "TERMS", TERMS, TERMS_MIN, TERMS_MAX)
  `AOI_PIPE_CHECK_RANGE(g_chk_invert, "INVERT", INVERT, 0, 1)
  `AOI_PIPE_CHECK_RANGE(g_chk_stages, "STAGES", STAGES, STAGES_MIN, STAGES_MAX)

  typedef `AOI_PIPE_TRIPLE_T(GW) triple_t;

  localparam triple_t RESET_TRIPLE = '{
    zn:      (INVERT != 0),
    multi:   1'b0,
    grp_idx: GW'(GROUPS)
  };

  logic [GROUPS-1:0] grp_hit;
  logic              seen_hit;
  logic              ready_chain;
  triple_t           eval_triple;
  logic [STAGES:0]   valid_vec;
  logic [STAGES:0]   ready_vec;
  triple_t           data_vec [STAGES+1];

  always_comb begin
    for (int g = 0; g < GROUPS; g++) begin
      grp_hit[g] = &A[g*TERMS +: TERMS];
    end
  end

  // The first hit sets the index, any later hit marks MULTI.
  always_comb begin
    eval_triple = RESET_TRIPLE;
    seen_hit    = 1'b0;
    for (int g = 0; g < GROUPS; g++) begin
      if (grp_hit[g]) begin
        if (seen_hit) eval_triple.multi = 1'b1;
        else eval_triple.grp_idx = GW'(g);
        seen_hit = 1'b1;
      end
    end
    eval_triple.zn = (INVERT != 0) ? ~seen_hit : seen_hit;
  end

  // Ready ripples back from OUT_READY; an empty slot is always ready.
  always_comb begin
    ready_chain       = OUT_READY;
    ready_vec[STAGES] = ready_chain;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ready_chain  = ~valid_vec[k+1] | ready_chain;
      ready_vec[k] = ready_chain;
    end
  end

  assign valid_vec[0] = IN_VALID;
  assign data_vec[0]  = eval_triple;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    gf180mcu_fd_sc_mcu7t5v0__aoi_pipe_stage #(
      .T          (triple_t),
      .RESET_DATA (RESET_TRIPLE)
    ) u_stage (
      .clk      (CLK),
      .rst      (RST),
      .up_valid (valid_vec[k]),
      .up_data  (data_vec[k]),
      .dn_ready (ready_vec[k+1]),
      .dn_valid (valid_vec[k+1]),
      .dn_data  (data_vec[k+1])
    );
  end

  assign IN_READY  = ready_vec[0];
  assign OUT_VALID = valid_vec[STAGES];
  assign ZN        = data_vec[STAGES].zn;
  assign MULTI     = data_vec[STAGES].multi;
  assign GRP_IDX   = data_vec[STAGES].grp_idx;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__aoi_pipe.sv
// Bench for the AOI pipe: a 3-stage default-size instance and a 1-stage
// 5x3 AO instance, both scored against an arithmetic group-hit model.
module tb_gf180mcu_fd_sc_mcu7t5v0__aoi_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [5:0]  a3;
  logic        iv3, ir3, zn3, mu3, ov3, or3;
  logic [1:0]  gi3;
  logic [14:0] a5;
  logic        iv5, ir5, zn5, mu5, ov5, or5;
  logic [2:0]  gi5;

  int total = 0;
  int bad   = 0;
  int win3  = 0;
  int win5  = 0;

  typedef struct {
    logic        zn;
    logic        multi;
    int          idx;
    logic [63:0] a;
    int          win;
  } exp_t;

  exp_t q3[$];
  exp_t q5[$];

  gf180mcu_fd_sc_mcu7t5v0__aoi_pipe #(
    .GROUPS(3), .TERMS(2), .INVERT(1), .STAGES(3)
  ) dut3 (
    .CLK(clk), .RST(rst), .A(a3), .IN_VALID(iv3), .IN_READY(ir3),
    .ZN(zn3), .MULTI(mu3), .GRP_IDX(gi3), .OUT_VALID(ov3), .OUT_READY(or3)
  );

  gf180mcu_fd_sc_mcu7t5v0__aoi_pipe #(
    .GROUPS(5), .TERMS(3), .INVERT(0), .STAGES(1)
  ) dut5 (
    .CLK(clk), .RST(rst), .A(a5), .IN_VALID(iv5), .IN_READY(ir5),
    .ZN(zn5), .MULTI(mu5), .GRP_IDX(gi5), .OUT_VALID(ov5), .OUT_READY(or5)
  );

  // Count fully-true groups by shifting and masking the input word.
  function automatic exp_t model(input int groups, input int terms, input int inv,
                                 input logic [63:0] a, input int win);
    exp_t        e;
    int          hits;
    logic [63:0] mask;
    hits  = 0;
    e.idx = groups;
    mask  = (64'd1 << terms) - 64'd1;
    for (int g = 0; g < groups; g++) begin
      if (((a >> (g * terms)) & mask) == mask) begin
        if (hits == 0) e.idx = g;
        hits++;
      end
    end
    e.multi = (hits >= 2);
    e.zn    = (inv != 0) ? (hits == 0) : (hits != 0);
    e.a     = a;
    e.win   = win;
    return e;
  endfunction

  task automatic step3(input logic v, input logic [5:0] a, input logic ordy,
                       output logic acc, output logic emit, output int w);
    @(negedge clk);
    iv3 = v; a3 = a; or3 = ordy;
    #1;
    acc  = iv3 & ir3;
    emit = ov3 & or3;
    w    = win3;
    if (acc) q3.push_back(model(3, 2, 1, {58'd0, a}, win3));
    win3++;
  endtask

  task automatic step5(input logic v, input logic [14:0] a, input logic ordy,
                       output logic acc, output logic emit);
    @(negedge clk);
    iv5 = v; a5 = a; or5 = ordy;
    #1;
    acc  = iv5 & ir5;
    emit = ov5 & or5;
    if (acc) q5.push_back(model(5, 3, 0, {49'd0, a}, win5));
    win5++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    iv3 = 1'b1; a3 = 6'h3f; or3 = 1'b0;
    iv5 = 1'b1; a5 = '1;    or5 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; iv3 = 1'b0; iv5 = 1'b0; or3 = 1'b1; or5 = 1'b1;
    #1;
    total++;
    if ({ov3, zn3, mu3, gi3, ir3} !== {1'b0, 1'b1, 1'b0, 2'd3, 1'b1}) begin
      bad++;
      $display("[TB] FAIL reset3: got v=%b zn=%b m=%b idx=%0d rdy=%b want v=0 zn=1 m=0 idx=3 rdy=1",
               ov3, zn3, mu3, gi3, ir3);
    end
    total++;
    if ({ov5, zn5, mu5, gi5, ir5} !== {1'b0, 1'b0, 1'b0, 3'd5, 1'b1}) begin
      bad++;
      $display("[TB] FAIL reset5: got v=%b zn=%b m=%b idx=%0d rdy=%b want v=0 zn=0 m=0 idx=5 rdy=1",
               ov5, zn5, mu5, gi5, ir5);
    end
    q3.delete(); q5.delete();
  endtask

  task automatic test_aoi_stream();
    logic acc, emit;
    int   w, stalls, emitted;
    exp_t e;
    stalls = 0; emitted = 0;
    for (int i = 0; i < 64 + 8; i++) begin
      step3(i < 64, 6'(i), 1'b1, acc, emit, w);
      if (i < 64 && !acc) stalls++;
      if (emit) begin
        emitted++;
        total++;
        if (q3.size() == 0) begin
          bad++;
          $display("[TB] FAIL stream_extra: got output idx=%0d want none", gi3);
        end else begin
          e = q3.pop_front();
          if (zn3 !== e.zn || mu3 !== e.multi || gi3 !== e.idx[1:0] || w - e.win != 3) begin
            bad++;
            $display("[TB] FAIL stream a=%b: got zn=%b m=%b idx=%0d lat=%0d want zn=%b m=%b idx=%0d lat=3",
                     e.a[5:0], zn3, mu3, gi3, w - e.win, e.zn, e.multi, e.idx);
          end
          if (e.a[5:0] == 6'b001111) begin
            total++;
            if ({zn3, mu3, gi3} !== {1'b0, 1'b1, 2'd0}) begin
              bad++;
              $display("[TB] FAIL aoi_001111: got zn=%b m=%b idx=%0d want zn=0 m=1 idx=0", zn3, mu3, gi3);
            end
          end
          if (e.a[5:0] == 6'b110000) begin
            total++;
            if ({zn3, mu3, gi3} !== {1'b0, 1'b0, 2'd2}) begin
              bad++;
              $display("[TB] FAIL aoi_110000: got zn=%b m=%b idx=%0d want zn=0 m=0 idx=2", zn3, mu3, gi3);
            end
          end
        end
      end
    end
    total++;
    if (stalls != 0 || emitted != 64) begin
      bad++;
      $display("[TB] FAIL stream_rate: got stalls=%0d emitted=%0d want stalls=0 emitted=64", stalls, emitted);
    end
  endtask

  task automatic test_backpressure();
    logic       acc, emit;
    int         w, emitted;
    exp_t       e;
    logic [5:0] vals [4];
    vals[0] = 6'b000011; vals[1] = 6'b001100; vals[2] = 6'b110000; vals[3] = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      step3(1'b1, vals[i], 1'b0, acc, emit, w);
      total++;
      if (acc !== 1'b1) begin
        bad++;
        $display("[TB] FAIL bp_accept%0d: got acc=%b want 1", i, acc);
      end
    end
    step3(1'b1, vals[3], 1'b0, acc, emit, w);
    total++;
    if (acc !== 1'b0 || ov3 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_full: got acc=%b ov=%b want acc=0 ov=1", acc, ov3);
    end
    emitted = 0;
    for (int i = 0; i < 8; i++) begin
      step3(i == 0, vals[3], 1'b1, acc, emit, w);
      if (i == 0) begin
        total++;
        if (acc !== 1'b1 || emit !== 1'b1) begin
          bad++;
          $display("[TB] FAIL bp_same_cycle: got acc=%b emit=%b want acc=1 emit=1", acc, emit);
        end
      end
      if (emit) begin
        emitted++;
        total++;
        if (q3.size() == 0) begin
          bad++;
          $display("[TB] FAIL bp_extra: got output idx=%0d want none", gi3);
        end else begin
          e = q3.pop_front();
          if (zn3 !== e.zn || mu3 !== e.multi || gi3 !== e.idx[1:0]) begin
            bad++;
            $display("[TB] FAIL bp_order: got zn=%b m=%b idx=%0d want zn=%b m=%b idx=%0d",
                     zn3, mu3, gi3, e.zn, e.multi, e.idx);
          end
        end
      end
    end
    total++;
    if (emitted != 4 || q3.size() != 0) begin
      bad++;
      $display("[TB] FAIL bp_count: got emitted=%0d left=%0d want emitted=4 left=0", emitted, q3.size());
    end
  endtask

  task automatic test_bubble();
    logic       acc, emit;
    int         w, emitted;
    exp_t       e;
    logic [5:0] vals [3];
    vals[0] = 6'b110000; vals[1] = 6'b000011; vals[2] = 6'b001100;
    for (int i = 0; i < 5; i++) begin
      step3(i % 2 == 0, vals[i/2], 1'b0, acc, emit, w);
      total++;
      if (ir3 !== 1'b1) begin
        bad++;
        $display("[TB] FAIL bubble_ready%0d: got rdy=%b want 1", i, ir3);
      end
    end
    step3(1'b0, 6'd0, 1'b0, acc, emit, w);
    total++;
    if (ir3 !== 1'b0 || ov3 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bubble_full: got rdy=%b ov=%b want rdy=0 ov=1", ir3, ov3);
    end
    emitted = 0;
    for (int i = 0; i < 8; i++) begin
      step3(1'b0, 6'd0, 1'b1, acc, emit, w);
      if (emit) begin
        total++;
        if (emitted > 2 || gi3 !== vals[emitted] [5:4] - vals[emitted] [5:4] + ((emitted == 0) ? 2'd2 : (emitted == 1) ? 2'd0 : 2'd1)) begin
          bad++;
          $display("[TB] FAIL bubble_order%0d: got idx=%0d want idx=%0d",
                   emitted, gi3, (emitted == 0) ? 2 : (emitted == 1) ? 0 : 1);
        end
        emitted++;
        if (q3.size() != 0) e = q3.pop_front();
      end
    end
    total++;
    if (emitted != 3) begin
      bad++;
      $display("[TB] FAIL bubble_count: got emitted=%0d want 3", emitted);
    end
  endtask

  task automatic test_random_stall();
    logic acc, emit;
    int   w;
    exp_t e;
    for (int i = 0; i < 140; i++) begin
      step3((i < 100) ? 1'($urandom_range(0, 1)) : 1'b0, 6'($urandom | $urandom),
            (i < 100) ? 1'($urandom_range(0, 1)) : 1'b1, acc, emit, w);
      if (emit) begin
        total++;
        if (q3.size() == 0) begin
          bad++;
          $display("[TB] FAIL rand3_extra: got output idx=%0d want none", gi3);
        end else begin
          e = q3.pop_front();
          if (zn3 !== e.zn || mu3 !== e.multi || gi3 !== e.idx[1:0]) begin
            bad++;
            $display("[TB] FAIL rand3 a=%b: got zn=%b m=%b idx=%0d want zn=%b m=%b idx=%0d",
                     e.a[5:0], zn3, mu3, gi3, e.zn, e.multi, e.idx);
          end
        end
      end
    end
    total++;
    if (q3.size() != 0) begin
      bad++;
      $display("[TB] FAIL rand3_drain: got left=%0d want 0", q3.size());
    end
  endtask

  task automatic test_reset_mid();
    logic acc, emit;
    int   w, emitted;
    step3(1'b1, 6'b000011, 1'b0, acc, emit, w);
    step3(1'b1, 6'b001100, 1'b0, acc, emit, w);
    @(negedge clk);
    rst = 1'b1; iv3 = 1'b1; or3 = 1'b1;
    @(negedge clk);
    rst = 1'b0; iv3 = 1'b0;
    #1;
    total++;
    if ({ov3, zn3, mu3, gi3} !== {1'b0, 1'b1, 1'b0, 2'd3}) begin
      bad++;
      $display("[TB] FAIL midreset_state: got v=%b zn=%b m=%b idx=%0d want v=0 zn=1 m=0 idx=3",
               ov3, zn3, mu3, gi3);
    end
    q3.delete();
    emitted = 0;
    for (int i = 0; i < 6; i++) begin
      step3(1'b0, 6'd0, 1'b1, acc, emit, w);
      if (emit) emitted++;
    end
    total++;
    if (emitted != 0) begin
      bad++;
      $display("[TB] FAIL midreset_stale: got emitted=%0d want 0", emitted);
    end
  endtask

  task automatic test_sweep();
    logic acc, emit;
    exp_t e;
    step5(1'b1, 15'b111_000_000_000_000, 1'b1, acc, emit);
    step5(1'b0, 15'd0, 1'b1, acc, emit);
    total++;
    if ({ov5, zn5, mu5, gi5} !== {1'b1, 1'b1, 1'b0, 3'd4}) begin
      bad++;
      $display("[TB] FAIL sweep_grp4: got v=%b zn=%b m=%b idx=%0d want v=1 zn=1 m=0 idx=4",
               ov5, zn5, mu5, gi5);
    end
    step5(1'b1, 15'd0, 1'b1, acc, emit);
    step5(1'b0, 15'd0, 1'b1, acc, emit);
    total++;
    if ({ov5, zn5, mu5, gi5} !== {1'b1, 1'b0, 1'b0, 3'd5}) begin
      bad++;
      $display("[TB] FAIL sweep_zero: got v=%b zn=%b m=%b idx=%0d want v=1 zn=0 m=0 idx=5",
               ov5, zn5, mu5, gi5);
    end
    q5.delete();
    for (int i = 0; i < 90; i++) begin
      step5((i < 80) ? 1'($urandom_range(0, 1)) : 1'b0, 15'($urandom | $urandom),
            (i < 80) ? 1'($urandom_range(0, 1)) : 1'b1, acc, emit);
      if (emit) begin
        total++;
        if (q5.size() == 0) begin
          bad++;
          $display("[TB] FAIL rand5_extra: got output idx=%0d want none", gi5);
        end else begin
          e = q5.pop_front();
          if (zn5 !== e.zn || mu5 !== e.multi || gi5 !== e.idx[2:0]) begin
            bad++;
            $display("[TB] FAIL rand5 a=%b: got zn=%b m=%b idx=%0d want zn=%b m=%b idx=%0d",
                     e.a[14:0], zn5, mu5, gi5, e.zn, e.multi, e.idx);
          end
        end
      end
    end
    total++;
    if (q5.size() != 0) begin
      bad++;
      $display("[TB] FAIL rand5_drain: got left=%0d want 0", q5.size());
    end
  endtask

  initial begin
    test_reset();
    test_aoi_stream();
    test_backpressure();
    test_bubble();
    test_random_stall();
    test_reset_mid();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
